panzoom_readout: RTL and testbench

- Host-side reader for the panzoom capture buffer; drains the memory the capture engine fills.
- Waits for the capture engine to report stopped, then reads entries 0..N-1 with a fixed read latency.
- Serializes the NCHAN channels of each entry onto a single DW-wide valid/ready stream, channel 0 first.
- On completion, issues a one-cycle rearm pulse that drives the capture engine's reset input for the next acquisition.

---
 rtl/panzoom_readout_pkg.sv | 22 ++
 rtl/panzoom_readout_if.sv | 17 +
 rtl/panzoom_chan_ser.sv | 50 +++++
 rtl/panzoom_readout.sv | 108 ++++++++++
 tb/tb_panzoom_readout.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/panzoom_readout_pkg.sv
// Shared types and helpers for the panzoom capture-buffer readout path.
// Holds the readout FSM state encoding and the sample-count clamp.
package panzoom_readout_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_STOP = 3'd1,
    ST_READ      = 3'd2,
    ST_WAIT_DATA = 3'd3,
    ST_SEND      = 3'd4,
    ST_DONE      = 3'd5
  } state_t;

  // A count of zero, or one beyond the buffer depth, means "read the whole buffer".
  function automatic logic [31:0] clamp_nsamp(input logic [31:0] n, input int memaw);
    logic [31:0] depth;
    depth = 32'd1 << memaw;
    if (n == 32'd0 || n > depth) return depth;
    return n;
  endfunction

endpackage

// File: rtl/panzoom_readout_if.sv
// Sample stream leaving the panzoom readout: one channel word per beat.
// The reader is the master; the host-side sink is the slave.
interface panzoom_readout_if #(
  parameter int DW    = 16,
  parameter int NCHAN = 2
);
  localparam int CW = (NCHAN > 1) ? $clog2(NCHAN) : 1;

  logic [DW-1:0] out_data;
  logic [CW-1:0] out_chan;
  logic          out_valid;
  logic          out_ready;
  logic          out_last;

  modport master (output out_data, out_chan, out_valid, out_last, input out_ready);
  modport slave  (input out_data, out_chan, out_valid, out_last, output out_ready);
endinterface

// File: rtl/panzoom_chan_ser.sv
// Holds one buffer entry and serializes its channels onto the sample stream,
// channel 0 first; reports when the final channel of the entry is accepted.
module panzoom_chan_ser #(
  parameter int DW    = 16,
  parameter int NCHAN = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic [NCHAN*DW-1:0]   load_data,
  input  logic                  last_entry,
  output logic                  entry_done,
  panzoom_readout_if.master     strm
);
  localparam int CW = (NCHAN > 1) ? $clog2(NCHAN) : 1;

  logic [NCHAN-1:0][DW-1:0] holding;
  logic [CW-1:0]            chan;
  logic                     valid;
  logic                     last_chan;
  logic                     handshake;

  assign last_chan = (chan == CW'(NCHAN - 1));
  assign handshake = valid & strm.out_ready;

  // NOTE: the holding register is reset only because out_data must read 0 out
  // of reset; large sample memories elsewhere are deliberately left unreset.
  always_ff @(posedge clk) begin
    if (reset) begin
      holding <= '0;
      chan    <= '0;
      valid   <= 1'b0;
    end else if (load) begin
      holding <= load_data;
      chan    <= '0;
      valid   <= 1'b1;
    end else if (handshake) begin
      if (last_chan) valid <= 1'b0;
      else           chan  <= chan + CW'(1);
    end
  end

  // Outputs come straight from registers, so they hold still across a stall.
  assign strm.out_data  = holding[chan];
  assign strm.out_chan  = chan;
  assign strm.out_valid = valid;
  assign strm.out_last  = last_entry & last_chan & valid;
  assign entry_done     = handshake & last_chan;

endmodule

// File: rtl/panzoom_readout.sv
// Host-side reader for the panzoom capture buffer: waits for capture to stop,
// reads entries 0..N-1 one at a time, streams them out, then pulses rearm.
module panzoom_readout
  import panzoom_readout_pkg::*;
#(
  parameter int DW    = 16,
  parameter int NCHAN = 2,
  parameter int MEMAW = 10,
  parameter int RDLAT = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [MEMAW:0]      nsamp,
  input  logic                stopped,
  output logic [MEMAW-1:0]    rd_addr,
  output logic                rd_en,
  input  logic [NCHAN*DW-1:0] rd_data,
  panzoom_readout_if.master   out_if,
  output logic                busy,
  output logic                done,
  output logic                rearm
);
  localparam int LW = (RDLAT > 1) ? $clog2(RDLAT + 1) : 1;

  state_t        state, state_nxt;
  logic [MEMAW:0] entry;
  logic [MEMAW:0] nsamp_q;
  logic [LW-1:0]  lat_cnt;
  logic           load;
  logic           last_entry;
  logic           entry_done;

  // Entry counter is one bit wider than the address so a full-buffer read ends cleanly.
  assign last_entry = (entry == nsamp_q - (MEMAW + 1)'(1));
  assign load       = (state == ST_WAIT_DATA) && (lat_cnt == LW'(1));
  assign rd_addr    = entry[MEMAW-1:0];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its inputs from the same clock edge, independent of block order.
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:      if (start)        state_nxt = ST_WAIT_STOP;
      ST_WAIT_STOP: if (stopped)      state_nxt = ST_READ;
      ST_READ:                        state_nxt = ST_WAIT_DATA;
      ST_WAIT_DATA: if (load)         state_nxt = ST_SEND;
      ST_SEND:      if (entry_done)   state_nxt = last_entry ? ST_DONE : ST_READ;
      ST_DONE:                        state_nxt = ST_IDLE;
      default:                        state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    rd_en = 1'b0;
    busy  = 1'b1;
    done  = 1'b0;
    rearm = 1'b0;
    unique case (state)
      ST_IDLE: busy  = 1'b0;
      ST_READ: rd_en = 1'b1;
      ST_DONE: begin
        done  = 1'b1;
        rearm = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      entry   <= '0;
      nsamp_q <= '0;
      lat_cnt <= '0;
    end else begin
      unique case (state)
        ST_IDLE: if (start) begin
          nsamp_q <= (MEMAW + 1)'(clamp_nsamp(32'(nsamp), MEMAW));
          entry   <= '0;
        end
        ST_READ:      lat_cnt <= LW'(RDLAT);
        ST_WAIT_DATA: lat_cnt <= lat_cnt - LW'(1);
        ST_SEND:      if (entry_done && !last_entry) entry <= entry + (MEMAW + 1)'(1);
        default: ;
      endcase
    end
  end

  panzoom_chan_ser #(
    .DW   (DW),
    .NCHAN(NCHAN)
  ) u_ser (
    .clk       (clk),
    .reset     (reset),
    .load      (load),
    .load_data (rd_data),
    .last_entry(last_entry),
    .entry_done(entry_done),
    .strm      (out_if)
  );

endmodule

// File: tb/tb_panzoom_readout.sv
// Directed bench for panzoom_readout: a memory model plus an expected-word queue
// checked on every valid stream cycle, with literal pins on selected runs.
module tb_panzoom_readout;

  localparam int DW = 16, NCHAN = 2, MEMAW = 4, RDLAT = 2;

  typedef struct {
    logic [15:0] data;
    logic        chan;
    logic        last;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset, start, stopped;
  logic [4:0]  nsamp;
  logic [3:0]  rd_addr;
  logic        rd_en;
  logic [31:0] rd_data = '1;
  logic [31:0] d1 = '1;
  logic        busy, done, rearm;

  panzoom_readout_if #(.DW(DW), .NCHAN(NCHAN)) out_if ();

  panzoom_readout #(.DW(DW), .NCHAN(NCHAN), .MEMAW(MEMAW), .RDLAT(RDLAT)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .nsamp  (nsamp),
    .stopped(stopped),
    .rd_addr(rd_addr),
    .rd_en  (rd_en),
    .rd_data(rd_data),
    .out_if (out_if),
    .busy   (busy),
    .done   (done),
    .rearm  (rearm)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [3:0] a);
    return {16'(a) + 16'h0100, 16'(a)};
  endfunction

  // Two-stage read pipeline; all-ones marks cycles with no valid read data.
  always @(posedge clk) begin
    d1      <= rd_en ? mem_word(rd_addr) : '1;
    rd_data <= d1;
  end

  int total = 0, bad = 0;
  exp_t        q[$];
  logic [15:0] seen[$];
  int          last_pos = -1;
  int          rd_cnt = 0, done_cnt = 0, rearm_cnt = 0, max_addr = -1;
  logic        stall_prev = 1'b0;
  logic [15:0] d_prev;
  logic        c_prev, l_prev;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_expected(input int n);
    int m;
    m = (n == 0 || n > 16) ? 16 : n;
    for (int k = 0; k < m; k++) begin
      q.push_back('{data: 16'(k),          chan: 1'b0, last: 1'b0});
      q.push_back('{data: 16'(k + 'h100),  chan: 1'b1, last: (k == m - 1)});
    end
  endtask

  task automatic begin_run(input int n);
    push_expected(n);
    seen.delete();
    last_pos = -1;
    nsamp    = 5'(n);
    start    = 1'b1;
    tick();
    start    = 1'b0;
  endtask

  task automatic wait_done(input int budget, input bit toggle);
    int d0;
    d0 = done_cnt;
    for (int i = 0; i < budget; i++) begin
      if (done_cnt > d0) break;
      if (toggle) out_if.out_ready = ~out_if.out_ready;
      tick();
    end
    check("done_once", 32'(done_cnt - d0), 1);
    check("idle_after_done", busy, 0);
    check("all_words_seen", 32'(q.size()), 0);
    out_if.out_ready = 1'b1;
  endtask

  // Compare process: every valid stream cycle is checked against the queue head.
  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        stall_prev = 1'b0;
        continue;
      end
      if (rd_en) begin
        rd_cnt++;
        if (int'(rd_addr) > max_addr) max_addr = int'(rd_addr);
      end
      if (done)  done_cnt++;
      if (rearm) rearm_cnt++;
      if (done || rearm) check("rearm_with_done", rearm, done);
      if (stall_prev) begin
        check("stall_valid", out_if.out_valid, 1);
        check("stall_data",  out_if.out_data, d_prev);
        check("stall_chan",  out_if.out_chan, c_prev);
        check("stall_last",  out_if.out_last, l_prev);
      end
      if (!out_if.out_valid && out_if.out_last) check("last_without_valid", 1, 0);
      if (out_if.out_valid) begin
        if (q.size() == 0) begin
          check("unexpected_word", 1, 0);
        end else begin
          check("word_data", out_if.out_data, q[0].data);
          check("word_chan", out_if.out_chan, q[0].chan);
          check("word_last", out_if.out_last, q[0].last);
          if (out_if.out_ready) void'(q.pop_front());
        end
        if (out_if.out_ready) begin
          if (out_if.out_last) last_pos = seen.size();
          seen.push_back(out_if.out_data);
        end
      end
      stall_prev = out_if.out_valid && !out_if.out_ready;
      d_prev     = out_if.out_data;
      c_prev     = out_if.out_chan;
      l_prev     = out_if.out_last;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] exp1[6] = '{16'h0000, 16'h0100, 16'h0001, 16'h0101, 16'h0002, 16'h0102};
    logic [15:0] exp4[4] = '{16'h0000, 16'h0100, 16'h0001, 16'h0101};
    int rd0, dn0, rr0;
    logic found;

    reset = 1'b1; start = 1'b0; stopped = 1'b0; nsamp = '0;
    out_if.out_ready = 1'b1;
    repeat (3) tick();
    check("rst_valid", out_if.out_valid, 0);
    check("rst_last",  out_if.out_last, 0);
    check("rst_data",  out_if.out_data, 0);
    check("rst_chan",  out_if.out_chan, 0);
    check("rst_rd_en", rd_en, 0);
    check("rst_addr",  rd_addr, 0);
    check("rst_busy",  busy, 0);
    check("rst_done",  done | rearm, 0);
    reset = 1'b0;
    tick();

    // Three entries, always ready.
    stopped = 1'b1;
    rd0 = rd_cnt; rr0 = rearm_cnt;
    begin_run(3);
    check("busy_after_start", busy, 1);
    wait_done(200, 1'b0);
    check("t1_rd_count", 32'(rd_cnt - rd0), 3);
    check("t1_rearm_count", 32'(rearm_cnt - rr0), 1);
    check("t1_words", 32'(seen.size()), 6);
    for (int i = 0; i < 6; i++)
      if (i < seen.size()) check("t1_literal", seen[i], exp1[i]);
    check("t1_last_pos", 32'(last_pos), 5);

    // nsamp=0 reads the whole 16-entry buffer.
    rd0 = rd_cnt;
    begin_run(0);
    wait_done(400, 1'b0);
    check("t2_words", 32'(seen.size()), 32);
    if (seen.size() == 32) check("t2_final_word", seen[31], 16'h010F);
    check("t2_last_pos", 32'(last_pos), 31);
    check("t2_rd_count", 32'(rd_cnt - rd0), 16);
    check("t2_max_addr", 32'(max_addr), 15);

    // Hold off until the capture engine reports stopped.
    stopped = 1'b0;
    rd0 = rd_cnt;
    begin_run(1);
    repeat (10) tick();
    check("t3_no_read_early", 32'(rd_cnt - rd0), 0);
    check("t3_busy_waiting", busy, 1);
    stopped = 1'b1;
    check("t3_rd_en_same_cycle", rd_en, 0);
    tick();
    check("t3_rd_en_next_cycle", rd_en, 1);
    check("t3_rd_addr", rd_addr, 0);
    wait_done(100, 1'b0);

    // Back-pressure: ready toggles every cycle.
    begin_run(2);
    wait_done(200, 1'b1);
    check("t4_words", 32'(seen.size()), 4);
    for (int i = 0; i < 4; i++)
      if (i < seen.size()) check("t4_literal", seen[i], exp4[i]);

    // Reset while streaming entry 1.
    dn0 = done_cnt;
    begin_run(3);
    found = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (out_if.out_valid && out_if.out_data == 16'h0001) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    check("t5_reached_entry1", found, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    q.delete();
    check("t5_valid_cleared", out_if.out_valid, 0);
    check("t5_busy_cleared", busy, 0);
    check("t5_no_done", done, 0);
    repeat (5) tick();
    check("t5_no_done_after", 32'(done_cnt - dn0), 0);
    begin_run(1);
    wait_done(100, 1'b0);
    check("t5_words", 32'(seen.size()), 2);
    if (seen.size() == 2) begin
      check("t5_word0", seen[0], 16'h0000);
      check("t5_word1", seen[1], 16'h0100);
    end

    // A second start while busy is ignored, including its nsamp.
    stopped = 1'b0;
    dn0 = done_cnt;
    begin_run(2);
    tick();
    start = 1'b1;
    nsamp = 5'd5;
    repeat (3) tick();
    start = 1'b0;
    stopped = 1'b1;
    wait_done(200, 1'b0);
    repeat (10) tick();
    check("t6_single_done", 32'(done_cnt - dn0), 1);
    check("t6_words", 32'(seen.size()), 4);
    check("t6_idle", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
